// File: rtl/rca_nibble_seq.sv
// Multi-cycle W-bit adder that reuses one 4-bit ripple-carry adder, one nibble per clock,
// LSB nibble first, with the carry chained through a register between nibbles.
`timescale 1ns/1ps

module rca4b (
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic cin,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic cout
);
    logic c1, c2, c3;

    assign s0   = a0 ^ b0 ^ cin;
    assign c1   = (a0 & b0) | (a0 & cin) | (b0 & cin);
    assign s1   = a1 ^ b1 ^ c1;
    assign c2   = (a1 & b1) | (a1 & c1) | (b1 & c1);
    assign s2   = a2 ^ b2 ^ c2;
    assign c3   = (a2 & b2) | (a2 & c2) | (b2 & c2);
    assign s3   = a3 ^ b3 ^ c3;
    assign cout = (a3 & b3) | (a3 & c3) | (b3 & c3);
endmodule

module rca_nibble_seq #(
    parameter int unsigned NIB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NIB-1:0]  sum,
    output logic              cout,
    output logic              ovf
);
    localparam int unsigned W    = 4 * NIB;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [W-1:0]      opa_q, opb_q, work_q, work_d;
    logic              carry_q;
    logic [IdxW-1:0]   idx_q;
    logic [IdxW+1:0]   shamt;
    logic [3:0]        nib_a, nib_b, nib_s;
    logic              nib_cout;
    logic              last_nib;
    logic              ovf_d;

    assign shamt    = {idx_q, 2'b00};
    assign last_nib = (idx_q == IdxW'(NIB - 1));

    always_comb begin
        nib_a  = 4'(opa_q >> shamt);
        nib_b  = 4'(opb_q >> shamt);
        // Splice the fresh nibble into the partial result; bits above it are still zero.
        work_d = (work_q & ~(W'(4'hF) << shamt)) | (W'(nib_s) << shamt);
        ovf_d  = (opa_q[W-1] == opb_q[W-1]) && (nib_s[3] != opa_q[W-1]);
    end

    rca4b u_rca4b (
        .a0   (nib_a[0]),
        .a1   (nib_a[1]),
        .a2   (nib_a[2]),
        .a3   (nib_a[3]),
        .b0   (nib_b[0]),
        .b1   (nib_b[1]),
        .b2   (nib_b[2]),
        .b3   (nib_b[3]),
        .cin  (carry_q),
        .s0   (nib_s[0]),
        .s1   (nib_s[1]),
        .s2   (nib_s[2]),
        .s3   (nib_s[3]),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= cin;
                        work_q  <= '0;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    work_q  <= work_d;
                    carry_q <= nib_cout;
                    if (last_nib) begin
                        sum     <= work_d;
                        cout    <= nib_cout;
                        ovf     <= ovf_d;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rca_nibble_seq.sv
// Directed and random checks of rca_nibble_seq at NIB=4 and NIB=1.
`timescale 1ns/1ps

module tb_rca_nibble_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start4, cin4, busy4, done4, cout4, ovf4;
    logic [15:0] a4, b4, sum4;
    logic        start1, cin1, busy1, done1, cout1, ovf1;
    logic [3:0]  a1, b1, sum1;

    int errors = 0;
    int checks = 0;

    rca_nibble_seq #(.NIB(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    rca_nibble_seq #(.NIB(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op4(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic [15:0] es, input logic ec, input logic eo);
        int lat, busyc;
        bit both;
        lat = 0; busyc = 0; both = 0;
        @(negedge clk);
        a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; a4 = ~ta; b4 = ~tb_; cin4 = ~tc;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (busy4 && done4) both = 1;
            if (busy4) busyc++;
            if (done4) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_busycycles"}, busyc, 4);
        check({tag, "_busydone"}, 32'(both), 0);
        check({tag, "_sum"}, sum4, es);
        check({tag, "_cout"}, cout4, ec);
        check({tag, "_ovf"}, ovf4, eo);
    endtask

    task automatic op1(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                       input logic tc, input logic [3:0] es, input logic ec, input logic eo);
        int lat, busyc;
        lat = 0; busyc = 0;
        @(negedge clk);
        a1 = ta; b1 = tb_; cin1 = tc; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; a1 = ~ta; b1 = ~tb_;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (busy1) busyc++;
            if (done1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_busycycles"}, busyc, 1);
        check({tag, "_sum"}, sum1, es);
        check({tag, "_cout"}, cout1, ec);
        check({tag, "_ovf"}, ovf1, eo);
    endtask

    initial begin
        logic [15:0] ta, tb_, last_sum, fa;
        logic [16:0] r;
        logic [3:0]  sa, sb;
        logic [4:0]  r1;
        logic        tc;

        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #12;
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_sum", sum4, 0);
        check("rst_cout", cout4, 0);
        check("rst_ovf", ovf4, 0);
        check("rst_sum1", sum1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        op4("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        op4("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op4("posovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op4("negovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        op4("ripple",   16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
        op4("cinonly",  16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        op4("allones",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // start held high: accepts every NIB+2 cycles, results follow accept-edge operands.
        last_sum = sum4;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (i % 6 == 5) begin
                    fa = 16'(i - 5) * 16'h0101 + 16'h0F0F;
                    check("hold_done", done4, 1);
                    check("hold_sum", sum4, fa + 16'h1111);
                    last_sum = fa + 16'h1111;
                end else begin
                    check("hold_nodone", done4, 0);
                    if (i > 5) check("hold_stable", sum4, last_sum);
                end
            end
            a4 = 16'(i) * 16'h0101 + 16'h0F0F;
            b4 = 16'h1111; cin4 = 1'b0; start4 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset after two nibbles have been written.
        a4 = 16'h1234; b4 = 16'h1111; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_sum", sum4, 0);
        check("abort_cout", cout4, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_nodone", done4, 0);
        end
        rst_n = 1'b1;
        op4("post_rst", 16'h0005, 16'h0005, 1'b0, 16'h000A, 1'b0, 1'b0);

        op1("n1_posovf", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        op1("n1_wrap",   4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        op1("n1_cin",    4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            ta = 16'($urandom); tb_ = 16'($urandom); tc = 1'($urandom);
            r = {1'b0, ta} + {1'b0, tb_} + 17'(tc);
            op4("rnd4", ta, tb_, tc, r[15:0], r[16], (ta[15] == tb_[15]) && (r[15] != ta[15]));
        end
        for (int n = 0; n < 1000; n++) begin
            sa = 4'($urandom); sb = 4'($urandom); tc = 1'($urandom);
            r1 = {1'b0, sa} + {1'b0, sb} + 5'(tc);
            op1("rnd1", sa, sb, tc, r1[3:0], r1[4], (sa[3] == sb[3]) && (r1[3] != sa[3]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
